// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port access controller for the 64 x 9 unified memory.
// Port 0 is the CPU, port 1 is the loader/debug port. Each granted request
// becomes a SETUP / STROBE / FINISH sequence that drives the memory's
// edge-triggered READ/WRITE strobes, followed by a one-cycle ACK to the winner.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN. When it is defined, tied
// requests are granted round-robin. When it is not defined, port 0 wins ties.
module mem_port_arbiter #(
    parameter int AW            = 6,
    parameter int DW            = 9,
    parameter int STROBE_CYCLES = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQ0,
    input  logic          WE0,
    input  logic [AW-1:0] A0,
    input  logic [DW-1:0] WDATA0,
    output logic          ACK0,
    output logic [DW-1:0] RDATA0,
    input  logic          REQ1,
    input  logic          WE1,
    input  logic [AW-1:0] A1,
    input  logic [DW-1:0] WDATA1,
    output logic          ACK1,
    output logic [DW-1:0] RDATA1,
    output logic          BUSY,
    output logic          MEM_READ,
    output logic          MEM_WRITE,
    output logic [AW-1:0] MEM_A,
    output logic [DW-1:0] MEM_DATA,
    input  logic [DW-1:0] MEM_D
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    // The counter reloads with the number of remaining strobe cycles minus one.
    localparam logic [3:0] CNT_INIT = 4'(STROBE_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       grant_port;
    logic       lat_we;
    logic       any_req;
    logic       winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic       last_grant;

    // Pick the winner. A lone request always wins. A tie goes to the port that was not served last.
    always_comb begin
        any_req = REQ0 | REQ1;
        if (REQ0 && REQ1) begin
            winner = ~last_grant;
        end else begin
            winner = ~REQ0;
        end
    end

    // Remember which port was granted most recently. Reset points at port 1, so port 0 wins the first tie.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_grant <= winner;
        end
    end
`else
    // Pick the winner with fixed priority: port 0 wins whenever it is requesting.
    always_comb begin
        any_req = REQ0 | REQ1;
        winner  = ~REQ0;
    end
`endif

    // Access sequencer: latch the winner, set up the address, pulse the strobe, then acknowledge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            grant_port <= 1'b0;
            lat_we     <= 1'b0;
            BUSY       <= 1'b0;
            MEM_READ   <= 1'b0;
            MEM_WRITE  <= 1'b0;
            MEM_A      <= '0;
            MEM_DATA   <= '0;
            ACK0       <= 1'b0;
            ACK1       <= 1'b0;
            RDATA0     <= '0;
            RDATA1     <= '0;
        end else begin
            ACK0 <= 1'b0;
            ACK1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= SETUP;
                        BUSY       <= 1'b1;
                        grant_port <= winner;
                        lat_we     <= winner ? WE1 : WE0;
                        MEM_A      <= winner ? A1 : A0;
                        MEM_DATA   <= winner ? WDATA1 : WDATA0;
                    end
                end
                SETUP: begin
                    state     <= STROBE;
                    cnt       <= CNT_INIT;
                    MEM_READ  <= ~lat_we;
                    MEM_WRITE <= lat_we;
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        state     <= FINISH;
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        ACK0      <= ~grant_port;
                        ACK1      <= grant_port;
                        if (!lat_we) begin
                            if (grant_port) begin
                                RDATA1 <= MEM_D;
                            end else begin
                                RDATA0 <= MEM_D;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. It runs a
// STROBE_CYCLES=1 instance against a behavioural edge-triggered memory and a
// STROBE_CYCLES=3 instance for strobe-length timing. Tie ordering depends on
// MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 9;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          REQ0, WE0, REQ1, WE1;
    logic [AW-1:0] A0, A1;
    logic [DW-1:0] WDATA0, WDATA1;
    logic          ACK0, ACK1, BUSY, MEM_READ, MEM_WRITE;
    logic [DW-1:0] RDATA0, RDATA1, MEM_DATA, MEM_D;
    logic [AW-1:0] MEM_A;

    logic          req_s;
    logic          ack0_s, ack1_s, busy_s, read_s, write_s;
    logic [DW-1:0] rdata0_s, rdata1_s, data_s, d_s;
    logic [AW-1:0] a_s;

    logic [DW-1:0] mem [64];
    bit            mem_valid [64];
    int            write_pulses = 0;
    logic [AW-1:0] last_wr_a;
    logic [DW-1:0] last_wr_d;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STROBE_CYCLES(1)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .WE0(WE0), .A0(A0), .WDATA0(WDATA0), .ACK0(ACK0), .RDATA0(RDATA0),
        .REQ1(REQ1), .WE1(WE1), .A1(A1), .WDATA1(WDATA1), .ACK1(ACK1), .RDATA1(RDATA1),
        .BUSY(BUSY), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_A(MEM_A), .MEM_DATA(MEM_DATA), .MEM_D(MEM_D)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .STROBE_CYCLES(3)) dut_slow (
        .CLK(CLK), .RESET(RESET),
        .REQ0(req_s), .WE0(WE0), .A0(A0), .WDATA0(WDATA0), .ACK0(ack0_s), .RDATA0(rdata0_s),
        .REQ1(1'b0), .WE1(1'b0), .A1('0), .WDATA1('0), .ACK1(ack1_s), .RDATA1(rdata1_s),
        .BUSY(busy_s), .MEM_READ(read_s), .MEM_WRITE(write_s),
        .MEM_A(a_s), .MEM_DATA(data_s), .MEM_D(d_s)
    );

    always #5 CLK = ~CLK;

    // Preloaded contents for words that have never been written.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        case (a)
            6'd2:    return 9'h122;
            6'd5:    return 9'h055;
            6'd7:    return 9'h077;
            6'd10:   return 9'h001;
            6'd11:   return 9'h0B2;
            default: return 9'h000;
        endcase
    endfunction

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem_valid[a] ? mem[a] : init_val(a);
    endfunction

    // Memory write port acts on the rising edge of MEM_WRITE.
    always @(posedge MEM_WRITE) begin
        mem[MEM_A]       <= MEM_DATA;
        mem_valid[MEM_A] <= 1'b1;
        write_pulses     <= write_pulses + 1;
        last_wr_a        <= MEM_A;
        last_wr_d        <= MEM_DATA;
    end

    // Memory read port acts on the rising edge of MEM_READ.
    always @(posedge MEM_READ) MEM_D <= mem_rd(MEM_A);

    // The slow instance reads the same array.
    always @(posedge read_s) d_s <= mem_rd(a_s);

    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Returns the number of falling edges until the port's ACK is seen, or -1 if it never arrives.
    task automatic wait_ack(input int port, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = -1;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge CLK);
            if ((port == 0 && ACK0 === 1'b1) || (port == 1 && ACK1 === 1'b1)) begin
                cycles = i;
                found  = 1'b1;
            end
        end
    endtask

    initial begin
        int lat;
        int wp0;
        int n0, n1;
        int order[$];
        int exp_order[8];
        logic [10:0] read_pat, ack_pat;

        RESET = 1'b1;
        REQ0 = 1'b0; WE0 = 1'b0; A0 = '0; WDATA0 = '0;
        REQ1 = 1'b0; WE1 = 1'b0; A1 = '0; WDATA1 = '0;
        req_s = 1'b0;
        $display("[TB] start");

        // Reset state
        repeat (2) @(negedge CLK);
        check_output("rst_busy", BUSY, 0);
        check_output("rst_strobes", {MEM_READ, MEM_WRITE}, 0);
        check_output("rst_acks", {ACK0, ACK1}, 0);
        check_output("rst_mem_a", MEM_A, 0);
        check_output("rst_mem_data", MEM_DATA, 0);
        check_output("rst_rdata0", RDATA0, 0);
        check_output("rst_rdata1", RDATA1, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // Port 0 reads word 10 with a one-cycle strobe
        REQ0 = 1'b1; WE0 = 1'b0; A0 = 6'd10;
        @(negedge CLK);
        check_output("rd10_setup_busy", BUSY, 1);
        check_output("rd10_setup_read", MEM_READ, 0);
        check_output("rd10_setup_addr", MEM_A, 10);
        @(negedge CLK);
        check_output("rd10_strobe_read", MEM_READ, 1);
        check_output("rd10_strobe_write", MEM_WRITE, 0);
        check_output("rd10_strobe_ack", ACK0, 0);
        check_output("rd10_strobe_busy", BUSY, 1);
        @(negedge CLK);
        check_output("rd10_fin_read", MEM_READ, 0);
        check_output("rd10_fin_ack0", ACK0, 1);
        check_output("rd10_fin_ack1", ACK1, 0);
        check_output("rd10_fin_rdata", RDATA0, 9'h001);
        check_output("rd10_fin_busy", BUSY, 1);
        REQ0 = 1'b0;
        @(negedge CLK);
        check_output("rd10_idle_busy", BUSY, 0);
        check_output("rd10_idle_ack", ACK0, 0);

        // Port 1 writes 1A5 to word 63, then port 0 reads it back
        wp0 = write_pulses;
        REQ1 = 1'b1; WE1 = 1'b1; A1 = 6'd63; WDATA1 = 9'h1A5;
        wait_ack(1, lat);
        check_output("wr63_latency", 16'(lat), 3);
        check_output("wr63_pulses", 16'(write_pulses - wp0), 1);
        check_output("wr63_addr", last_wr_a, 63);
        check_output("wr63_data", last_wr_d, 9'h1A5);
        REQ1 = 1'b0;
        @(negedge CLK);
        REQ0 = 1'b1; WE0 = 1'b0; A0 = 6'd63;
        wait_ack(0, lat);
        check_output("rd63_latency", 16'(lat), 3);
        check_output("rd63_rdata0", RDATA0, 9'h1A5);
        check_output("rd63_rdata1", RDATA1, 0);
        check_output("rd63_no_write", 16'(write_pulses - wp0), 1);
        REQ0 = 1'b0;
        @(negedge CLK);

        // Both ports hold requests for four reads each
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{1, 0, 1, 0, 1, 0, 1, 0};
`else
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        n0 = 0; n1 = 0;
        REQ0 = 1'b1; WE0 = 1'b0; A0 = 6'd63;
        REQ1 = 1'b1; WE1 = 1'b0; A1 = 6'd2;
        for (int i = 0; i < 60 && (n0 < 4 || n1 < 4); i++) begin
            @(negedge CLK);
            if (ACK0 === 1'b1) begin
                order.push_back(0);
                n0++;
                if (n0 == 4) REQ0 = 1'b0;
            end
            if (ACK1 === 1'b1) begin
                order.push_back(1);
                n1++;
                if (n1 == 4) REQ1 = 1'b0;
            end
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        check_output("tie_count", 16'(order.size()), 8);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("tie_grant%0d", i), 16'(i < order.size() ? order[i] : 9), 16'(exp_order[i]));
        end
        check_output("tie_rdata0", RDATA0, 9'h1A5);
        check_output("tie_rdata1", RDATA1, 9'h122);
        @(negedge CLK);

        // Address change after grant has no effect
        REQ0 = 1'b1; WE0 = 1'b0; A0 = 6'd5;
        @(negedge CLK);
        A0 = 6'd7;
        check_output("hold_addr_setup", MEM_A, 5);
        @(negedge CLK);
        check_output("hold_addr_strobe", MEM_A, 5);
        @(negedge CLK);
        check_output("hold_ack", ACK0, 1);
        check_output("hold_addr_finish", MEM_A, 5);
        check_output("hold_rdata", RDATA0, 9'h055);
        REQ0 = 1'b0;
        @(negedge CLK);

        // Reset during the strobe of a port 1 write
        wp0 = write_pulses;
        REQ1 = 1'b1; WE1 = 1'b1; A1 = 6'd20; WDATA1 = 9'h0FF;
        @(negedge CLK);
        @(negedge CLK);
        check_output("rst_mid_write_high", MEM_WRITE, 1);
        RESET = 1'b1;
        #1;
        check_output("rst_mid_write", MEM_WRITE, 0);
        check_output("rst_mid_busy", BUSY, 0);
        check_output("rst_mid_acks", {ACK0, ACK1}, 0);
        check_output("rst_mid_mem_a", MEM_A, 0);
        check_output("rst_mid_mem_data", MEM_DATA, 0);
        check_output("rst_mid_rdata", {RDATA0, RDATA1}, 0);
        REQ1 = 1'b0;
        @(negedge CLK);
        check_output("rst_mid_no_ack", ACK1, 0);
        check_output("rst_mid_committed", 16'(write_pulses - wp0), 1);
        RESET = 1'b0;
        @(negedge CLK);
        REQ0 = 1'b1; WE0 = 1'b0; A0 = 6'd20;
        wait_ack(0, lat);
        check_output("post_rst_latency", 16'(lat), 3);
        check_output("post_rst_rdata", RDATA0, 9'h0FF);
        REQ0 = 1'b0;
        @(negedge CLK);

        // Three-cycle strobe instance, two back-to-back reads of word 11
        WE0 = 1'b0; A0 = 6'd11;
        req_s = 1'b1;
        read_pat = '0;
        ack_pat  = '0;
        for (int k = 0; k < 11; k++) begin
            @(negedge CLK);
            read_pat[k] = read_s;
            ack_pat[k]  = ack0_s;
            if (k == 10) req_s = 1'b0;
        end
        check_output("slow_read_pattern", 16'(read_pat), 16'(11'b01110001110));
        check_output("slow_ack_pattern", 16'(ack_pat), 16'(11'b10000010000));
        check_output("slow_rdata", rdata0_s, 9'h0B2);
        @(negedge CLK);
        check_output("slow_idle_busy", busy_s, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
